// File: rtl/regfile_pkg.sv
// Shared constants and address helpers for the 2-read/1-write register file.
// Pure definitions; no timing or flow control of its own.
package regfile_pkg;

  localparam int REGFILE_DATA_W = 4;
  localparam int REGFILE_ADDR_W = 3;
  localparam int REGFILE_DEPTH  = 8;

  // True when addr selects an implemented row.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

  // Width needed to index 'depth' rows; never narrower than one bit.
  function automatic int idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port with write-first/clear-first bypass and range check.
// Latency 1 cycle; no backpressure, a read issued on any edge is always accepted.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int                 DATA_W    = REGFILE_DATA_W,
  parameter int                 ADDR_W    = REGFILE_ADDR_W,
  parameter int                 DEPTH     = REGFILE_DEPTH,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem [DEPTH],
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              byp_we,
  input  logic [ADDR_W-1:0] byp_addr,
  input  logic [DATA_W-1:0] byp_data,
  input  logic              clr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              rng_err
);

  localparam int IDX_W = idx_w(DEPTH);

  logic              hit;
  logic [IDX_W-1:0]  ridx;
  logic [DATA_W-1:0] rd_next;

  assign hit  = in_range(32'(raddr), DEPTH);
  assign ridx = raddr[IDX_W-1:0];

  // Same-edge clear wins over a same-edge write, which wins over stored data.
  always_comb begin
    rd_next = '0;
    if (!hit)
      rd_next = '0;
    else if (clr)
      rd_next = RESET_VAL;
    else if (byp_we && (byp_addr == raddr))
      rd_next = byp_data;
    else
      rd_next = mem[ridx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata   <= '0;
      rvalid  <= 1'b0;
      rng_err <= 1'b0;
    end else begin
      rvalid  <= re;
      rng_err <= re && !hit;
      if (re)
        rdata <= rd_next;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised register file: one write port, two independent registered read ports.
// Latency 1 cycle on reads; no backpressure, every request is accepted each cycle.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int                 DATA_W    = REGFILE_DATA_W,
  parameter int                 ADDR_W    = REGFILE_ADDR_W,
  parameter int                 DEPTH     = REGFILE_DEPTH,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              rvalid_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_b,
  output logic              err
);

  localparam int IDX_W = idx_w(DEPTH);

  // Only implemented rows exist; addresses at or above DEPTH never reach storage.
  logic [DATA_W-1:0] mem [DEPTH];

  logic             w_hit;
  logic             wr_ok;
  logic [IDX_W-1:0] widx;
  logic             werr_q;
  logic             rerr_a;
  logic             rerr_b;

  assign w_hit = in_range(32'(waddr), DEPTH);
  assign wr_ok = we && !clr && w_hit;
  assign widx  = waddr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= RESET_VAL;
    end else if (wr_ok) begin
      mem[widx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      werr_q <= 1'b0;
    else
      werr_q <= we && !w_hit;
  end

  regfile_rd_port #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .RESET_VAL (RESET_VAL)
  ) u_rd_a (
    .clk      (clk),
    .rst      (rst),
    .mem      (mem),
    .re       (re_a),
    .raddr    (raddr_a),
    .byp_we   (wr_ok),
    .byp_addr (waddr),
    .byp_data (wdata),
    .clr      (clr),
    .rdata    (rdata_a),
    .rvalid   (rvalid_a),
    .rng_err  (rerr_a)
  );

  regfile_rd_port #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .RESET_VAL (RESET_VAL)
  ) u_rd_b (
    .clk      (clk),
    .rst      (rst),
    .mem      (mem),
    .re       (re_b),
    .raddr    (raddr_b),
    .byp_we   (wr_ok),
    .byp_addr (waddr),
    .byp_data (wdata),
    .clr      (clr),
    .rdata    (rdata_b),
    .rvalid   (rvalid_b),
    .rng_err  (rerr_b)
  );

  // All three error sources are already registered, so this is a clean one-cycle pulse.
  assign err = werr_q | rerr_a | rerr_b;

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised register file: one write port, two independent read ports (A/B), all on a single clock.
- Successor to the 8x4 single-port register file used in the lab projects. Adds parametrised width and depth, registered dual reads with valid flags, write-first bypass, bulk clear, and out-of-range address detection.
- Sits between the datapath/ALU stage and its operand sources.

Parameters:
- DATA_W, 4, data word width in bits (>=1).
- ADDR_W, 3, address width in bits (>=1).
- DEPTH, 8, number of implemented entries; legal range 1..2**ADDR_W.
- RESET_VAL, 0, value every entry takes on rst or clr (DATA_W bits).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- clr  in  1  bulk clear of all entries to RESET_VAL.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re_a  in  1  read enable, port A.
- raddr_a  in  ADDR_W  read address, port A.
- rdata_a  out  DATA_W  registered read data, port A.
- rvalid_a  out  1  rdata_a updated this cycle.
- re_b, raddr_b, rdata_b, rvalid_b: same as port A, for port B.
- err  out  1  one-cycle pulse: an out-of-range address was used the previous cycle.

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset (rst=1 at an edge):
  - all entries become RESET_VAL;
  - rdata_a/b become 0;
  - rvalid_a/b become 0;
  - err becomes 0.
  - rst overrides clr, we and re in the same cycle.
- Write: at an edge with we=1, rst=0, clr=0 and waddr<DEPTH, mem[waddr] takes wdata.
- Out-of-range write (waddr>=DEPTH): the write is dropped and err=1 next cycle.
- Clear: at an edge with clr=1 and rst=0, all entries become RESET_VAL. clr beats a simultaneous we, and that write is lost.
- Read latency is 1 cycle. At an edge with re_x=1, rdata_x gets the addressed word and rvalid_x=1 in the following cycle.
- When re_x=0: rvalid_x=0 next cycle and rdata_x holds its last value. No X outputs are allowed.
- Read-during-write, same address, same edge: write-first. rdata_x returns wdata (bypass), not the old contents.
- Read during clr, same edge: rdata_x returns RESET_VAL. clr-first applies, consistent with write-first.
- Out-of-range read (raddr_x>=DEPTH): rdata_x=0, rvalid_x=1, err=1 next cycle.
- err is the OR of all three out-of-range conditions for that edge. It is a single pulse and is not sticky.
- Ports A and B are fully independent. Reading the same address on both ports returns identical data.
- Entries hold their value indefinitely when neither we nor clr is asserted.
- Reset mid-operation: a read issued in the reset cycle produces rvalid=0, and a write in that cycle is discarded.
- Unused storage rows (DEPTH..2**ADDR_W-1) must not be synthesised.

Decomposition:
- Package regfile_pkg holds:
  - default constants REGFILE_DATA_W=4, REGFILE_ADDR_W=3, REGFILE_DEPTH=8;
  - a constant function in_range(addr, depth) used by the write path and both read ports.
- Sub-module regfile_rd_port, instantiated twice:
  - takes the mem array view, re, raddr, and the bypass inputs (we-qualified waddr/wdata, clr);
  - outputs registered rdata, rvalid and a per-port range error.
- The top level owns the storage array, the write/clear logic and the err OR.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles, then read A addr0 and B addr7.
  - Required: rdata_a=rdata_b=0, rvalid=1 one cycle after re, err=0.
- Write/readback (DATA_W=4, DEPTH=8):
  - Stimulus: write 6@0, 9@1, 15@4, 13@6, 10@7, then read each on A while B reads in reverse order.
  - Required: A returns 6,9,15,13,10 and B returns 10,13,15,9,6, each 1 cycle after its re.
- Bypass:
  - Stimulus: in one cycle, we=1 waddr=3 wdata=5 with re_a=1 raddr_a=3 (entry 3 previously 12).
  - Required: rdata_a=5 next cycle; a subsequent read of addr3 returns 5.
- Clear priority:
  - Stimulus: entries loaded as in the readback test; same cycle clr=1, we=1 waddr=2 wdata=7, re_b=1 raddr_b=4.
  - Required: rdata_b=0 next cycle; later reads of addr2 and addr4 return 0.
- Range error (DEPTH=6, ADDR_W=3):
  - Stimulus: write 9@6, then read A@7.
  - Required: err pulses for 1 cycle after each; entry contents unchanged; rdata_a=0 with rvalid_a=1.
- Reset mid-operation:
  - Stimulus: rst=1 together with we=1 waddr=1 wdata=3 and re_a=1.
  - Required: next cycle rvalid_a=0 and rdata_a=0; a later read of addr1 returns RESET_VAL.
